he_frame_ctrl: RTL

//  Frame sequencer for the histogram-equalisation core. Clears the core's histogram, admits exactly one

---
 rtl/he_pkg.sv | 8 +
 rtl/he_skid_buf.sv | 40 ++++
 rtl/he_frame_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/he_pkg.sv
// he_pkg: shared types and defaults for the histogram-equalisation core, its frame sequencer and bench
package he_pkg;
    localparam int PIX_W = 8;
    localparam int BINS = 2 ** PIX_W;
    localparam int DEF_IMG_W = 660;
    localparam int DEF_IMG_H = 440;
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, BUILD, DRAIN, FIN} state_t;
endpackage

// File: rtl/he_skid_buf.sv
// he_skid_buf: 2-entry in-order valid/ready buffer for LUT entries
//  clk, reset (async, active-low), flush (sync empty), push/push_data (caller guarantees space),
//  out_valid/out_ready/out_data (head entry), count (occupancy 0..2)
module he_skid_buf #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);
    logic [DW-1:0] mem [2];
    logic wr_ptr, rd_ptr, pop;
    assign out_valid = count != 2'd0;
    assign out_data = mem[rd_ptr];
    assign pop = out_valid && out_ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) mem[wr_ptr] <= push_data;
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/he_frame_ctrl.sv
// he_frame_ctrl: frame sequencer clearing the histogram, admitting one frame, building and draining the LUT
//  clk, reset (async, active-low); start/abort control; in_valid/in_ready/in_data pixel input;
//  core_clr/core_acc/core_addr/core_build_start/core_build_done/core_lut_data to the HE core;
//  lut_valid/lut_ready/lut_addr/lut_data LUT stream; busy, done pulse, sticky err_tmo
module he_frame_ctrl import he_pkg::*; #(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int BUILD_TMO = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic             core_clr,
    output logic             core_acc,
    output logic [PIX_W-1:0] core_addr,
    output logic             core_build_start,
    input  logic             core_build_done,
    input  logic [PIX_W-1:0] core_lut_data,
    output logic             lut_valid,
    input  logic             lut_ready,
    output logic [PIX_W-1:0] lut_addr,
    output logic [PIX_W-1:0] lut_data,
    output logic             busy,
    output logic             done,
    output logic             err_tmo
);
    localparam int NUM_PIX = IMG_W * IMG_H;
    localparam int PW = $clog2(NUM_PIX + 1);
    localparam int TW = $clog2(BUILD_TMO + 1);
    state_t state, nxt;
    logic [PW-1:0] pix_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [PIX_W:0] idx;
    logic [PIX_W-1:0] pend_addr;
    logic [1:0] sb_cnt;
    logic pend, go, acc, pop, issue, tmo_hit;
    // idx doubles as the clear index and the LUT read index; its top bit marks all 256 reads issued.
    // A read is issued only if the buffer, after this cycle's pop and the read already in flight,
    // holds at most one entry, so the new entry always finds space when it lands.
    always_comb begin
        go = state == IDLE && start && !abort;
        acc = state == ACCUM && in_valid;
        pop = lut_valid && lut_ready;
        issue = state == DRAIN && !idx[PIX_W] && ({1'b0, sb_cnt} + {2'b0, pend} <= 3'd1 + {2'b0, pop});
        tmo_hit = state == BUILD && !core_build_done && tmo_cnt == TW'(BUILD_TMO - 1);
        nxt = state;
        case (state)
            IDLE:    nxt = go ? CLEAR : IDLE;
            CLEAR:   nxt = idx == (PIX_W+1)'(BINS - 1) ? ACCUM : CLEAR;
            ACCUM:   nxt = acc && pix_cnt == PW'(NUM_PIX - 1) ? BUILD : ACCUM;
            BUILD:   nxt = core_build_done ? DRAIN : tmo_hit ? IDLE : BUILD;
            DRAIN:   nxt = pop && lut_addr == PIX_W'(BINS - 1) ? FIN : DRAIN;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
        in_ready = state == ACCUM;
        core_acc = acc;
        core_clr = state == CLEAR;
        core_build_start = state == BUILD && tmo_cnt == '0;
        core_addr = state == ACCUM ? in_data : (state == CLEAR || state == DRAIN) ? idx[PIX_W-1:0] : '0;
        busy = state != IDLE;
        done = state == FIN;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pix_cnt <= '0;
            tmo_cnt <= '0;
            idx <= '0;
            pend <= 1'b0;
            pend_addr <= '0;
            err_tmo <= 1'b0;
        end else begin
            state <= nxt;
            pix_cnt <= state == ACCUM && !abort ? pix_cnt + PW'(acc) : '0;
            tmo_cnt <= state == BUILD && !abort ? tmo_cnt + TW'(1) : '0;
            idx <= abort || nxt != state ? '0 : idx + (PIX_W+1)'(state == CLEAR || issue);
            pend <= issue && !abort;
            pend_addr <= idx[PIX_W-1:0];
            err_tmo <= tmo_hit && !abort ? 1'b1 : go ? 1'b0 : err_tmo;
        end
    end
    he_skid_buf #(.DW(2 * PIX_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort || state != DRAIN),
        .push      (pend),
        .push_data ({pend_addr, core_lut_data}),
        .out_ready (lut_ready),
        .out_valid (lut_valid),
        .out_data  ({lut_addr, lut_data}),
        .count     (sb_cnt)
    );
endmodule
